mk_xsim_top: RTL and testbench

Simulation top of the xsim portal platform. It polls request-portal message beats from software through the DPI call `dpi_msgSink_beat` and decodes portal messages. It executes the small built-in echo/add portal and returns indication messages through the DPI call `dpi_msgSource_beat`. It is instantiated directly under the simulator root, which drives the clock and reset.

---
 rtl/xsim_pkg.sv | 43 ++++
 rtl/xsim_beat_fifo.sv | 46 ++++
 rtl/mk_xsim_top.sv | 110 +++++++++++
 tb/tb_mk_xsim_top.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/xsim_pkg.sv
// Shared definitions for the xsim portal top, plus the software-side message
// endpoints that the portal calls once per clock edge.
package xsim_pkg;

  localparam int HDR_METHOD_W = 16;
  localparam int HDR_LEN_W    = 16;
  localparam int BEAT_W       = 32;

  localparam logic [HDR_METHOD_W-1:0] M_ECHO = 16'h0000;
  localparam logic [HDR_METHOD_W-1:0] M_ADD  = 16'h0001;
  localparam logic [HDR_METHOD_W-1:0] M_ERR  = 16'hFFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_ARGS, ST_EXEC, ST_RESP} parser_state_e;

  // Request beats queued by software and indication beats returned to it.
  int sink_q[$];
  int src_q[$];
  int sink_calls;
  int sink_accepts;
  int src_calls;
  int last_sink_portal;
  int last_src_portal;

  function automatic void dpi_msgSink_beat(input int portal, output int beat, output int src_rdy);
    sink_calls++;
    last_sink_portal = portal;
    if (sink_q.size() > 0) begin
      beat    = sink_q.pop_front();
      src_rdy = 1;
      sink_accepts++;
    end else begin
      beat    = 0;
      src_rdy = 0;
    end
  endfunction

  function automatic void dpi_msgSource_beat(input int portal, input int beat);
    src_calls++;
    last_src_portal = portal;
    src_q.push_back(beat);
  endfunction

endpackage

// File: rtl/xsim_beat_fifo.sv
// Synchronous FIFO of 32-bit indication beats with an occupancy count;
// the head entry is presented combinationally on pop_data.
module xsim_beat_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [31:0]              pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok  = push && (count != CW'(DEPTH));
  assign pop_ok   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mk_xsim_top.sv
// xsim portal top: polls request beats, runs the echo/add portal and returns
// two-beat indication messages through the indication FIFO.
module mk_xsim_top
  import xsim_pkg::*;
#(
  parameter int REQ_PORTAL = 0,
  parameter int IND_PORTAL = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] msgs_done,
  output logic [15:0] bad_msgs
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  parser_state_e  state;
  logic [31:0]    hdr_raw;
  logic [31:0]    arg0;
  logic [31:0]    arg1;
  logic [1:0]     arg_idx;
  logic [15:0]    remaining;
  logic [CW-1:0]  fifo_count;
  logic           push;
  logic           pop;
  logic [31:0]    push_data;
  logic [31:0]    pop_data;
  logic           poll;
  logic           op_ok;
  logic [15:0]    method;
  logic [15:0]    len;

  assign method = hdr_raw[31:16];
  assign len    = hdr_raw[15:0];

  // Two free entries cover both response beats of the message being parsed.
  assign poll = !RST && (state == ST_IDLE || state == ST_ARGS)
                && (fifo_count <= CW'(FIFO_DEPTH - 2));
  assign pop  = !RST && (fifo_count != '0);

  always_comb begin
    op_ok     = (method == M_ECHO && len == 16'd2) || (method == M_ADD && len == 16'd3);
    push      = (state == ST_EXEC) || (state == ST_RESP);
    push_data = '0;
    if (state == ST_EXEC)
      push_data = op_ok ? {method, 16'd2} : {M_ERR, 16'd2};
    else if (state == ST_RESP)
      push_data = !op_ok ? hdr_raw : (method == M_ADD) ? arg0 + arg1 : arg0;
  end

  always_ff @(posedge CLK) begin : sink_parser
    int sink_beat;
    int sink_rdy;
    if (RST) begin
      state     <= ST_IDLE;
      hdr_raw   <= '0;
      arg0      <= '0;
      arg1      <= '0;
      arg_idx   <= '0;
      remaining <= '0;
      msgs_done <= '0;
      bad_msgs  <= '0;
    end else begin
      if (poll) begin
        dpi_msgSink_beat(REQ_PORTAL, sink_beat, sink_rdy);
        if (sink_rdy != 0) begin
          if (state == ST_IDLE) begin
            hdr_raw   <= sink_beat;
            arg0      <= '0;
            arg1      <= '0;
            arg_idx   <= '0;
            // len 0 behaves as a lone header
            remaining <= (sink_beat[15:0] == 16'd0) ? 16'd0 : sink_beat[15:0] - 16'd1;
            state     <= (sink_beat[15:0] > 16'd1) ? ST_ARGS : ST_EXEC;
          end else begin
            if (arg_idx == 2'd0) arg0 <= sink_beat;
            else if (arg_idx == 2'd1) arg1 <= sink_beat;
            if (arg_idx != 2'd2) arg_idx <= arg_idx + 2'd1;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= ST_EXEC;
          end
        end
      end
      case (state)
        ST_EXEC: begin
          if (op_ok) msgs_done <= msgs_done + 32'd1;
          else if (bad_msgs != 16'hFFFF) bad_msgs <= bad_msgs + 16'd1;
          state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin : source
    if (pop) dpi_msgSource_beat(IND_PORTAL, int'(pop_data));
  end

  xsim_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mk_xsim_top.sv
// Bench for mk_xsim_top: software beats are queued in the package endpoint,
// indication beats are scoreboarded against expected responses.
module tb_mk_xsim_top;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [31:0] msgs_done;
  logic [15:0] bad_msgs;

  int checks;
  int errors;
  int edge_n;
  int out_seen;
  int last_acc_edge;
  int prev_acc;
  int max_count;
  int out_edge_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_done;
  logic [15:0] exp_bad;

  typedef struct packed {
    logic [2:0]        n;
    logic [3:0][31:0]  beats;
    logic [31:0]       hdr;
    logic [31:0]       pay;
    logic              d_done;
    logic              d_bad;
  } vec_t;

  vec_t vecs[8];

  mk_xsim_top #(.REQ_PORTAL(0), .IND_PORTAL(1), .FIFO_DEPTH(DEPTH)) dut (
    .CLK       (clk),
    .RST       (rst),
    .msgs_done (msgs_done),
    .bad_msgs  (bad_msgs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] act;
    if (xsim_pkg::sink_accepts != prev_acc) begin
      prev_acc      = xsim_pkg::sink_accepts;
      last_acc_edge = edge_n;
    end
    if (int'(dut.u_fifo.count) > max_count) max_count = int'(dut.u_fifo.count);
    while (xsim_pkg::src_q.size() > 0) begin
      act = xsim_pkg::src_q.pop_front();
      out_edge_q.push_back(edge_n);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", act);
      end else begin
        check($sformatf("beat%0d", out_seen), act, exp_q.pop_front());
      end
      out_seen++;
    end
  end

  task automatic wait_out(input int target, input int budget, input string name);
    int k = 0;
    while (out_seen < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, out_seen, target);
  endtask

  task automatic set_vec(input int i, input int n, input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3, input logic [31:0] hdr,
                         input logic [31:0] pay, input logic dd, input logic db);
    vecs[i].n        = 3'(n);
    vecs[i].beats[0] = b0;
    vecs[i].beats[1] = b1;
    vecs[i].beats[2] = b2;
    vecs[i].beats[3] = b3;
    vecs[i].hdr      = hdr;
    vecs[i].pay      = pay;
    vecs[i].d_done   = dd;
    vecs[i].d_bad    = db;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int a0;
    int k;
    int calls0;
    int src0;
    checks = 0; errors = 0; edge_n = 0; out_seen = 0; prev_acc = 0;
    last_acc_edge = 0; max_count = 0; exp_done = '0; exp_bad = '0;
    rst = 1'b1;

    set_vec(0, 2, 32'h0000_0002, 32'hDEAD_BEEF, '0, '0, 32'h0000_0002, 32'hDEAD_BEEF, 1'b1, 1'b0);
    set_vec(1, 3, 32'h0001_0003, 32'hFFFF_FFFF, 32'h0000_0002, '0, 32'h0001_0002, 32'h0000_0001, 1'b1, 1'b0);
    set_vec(2, 4, 32'h0007_0004, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hFFFF_0002, 32'h0007_0004, 1'b0, 1'b1);
    set_vec(3, 2, 32'h0000_0002, 32'hCAFE_F00D, '0, '0, 32'h0000_0002, 32'hCAFE_F00D, 1'b1, 1'b0);
    set_vec(4, 1, 32'h0000_0000, '0, '0, '0, 32'hFFFF_0002, 32'h0000_0000, 1'b0, 1'b1);
    set_vec(5, 3, 32'h0001_0003, 32'h0000_0005, 32'h0000_0007, '0, 32'h0001_0002, 32'h0000_000C, 1'b1, 1'b0);
    set_vec(6, 3, 32'h0000_0003, 32'h0000_000A, 32'h0000_000B, '0, 32'hFFFF_0002, 32'h0000_0003, 1'b0, 1'b1);
    set_vec(7, 2, 32'h0001_0002, 32'h0000_0009, '0, '0, 32'hFFFF_0002, 32'h0001_0002, 1'b0, 1'b1);

    repeat (10) @(negedge clk);
    #1;
    check("reset_sink_calls", xsim_pkg::sink_calls, 0);
    check("reset_src_calls", xsim_pkg::src_calls, 0);
    check("reset_msgs_done", msgs_done, 32'd0);
    check("reset_bad_msgs", {16'd0, bad_msgs}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("first_poll", xsim_pkg::sink_calls, 1);

    for (int i = 0; i < 8; i++) begin
      base = out_seen;
      exp_q.push_back(vecs[i].hdr);
      exp_q.push_back(vecs[i].pay);
      for (int j = 0; j < int'(vecs[i].n); j++) xsim_pkg::sink_q.push_back(int'(vecs[i].beats[j]));
      exp_done = exp_done + 32'(vecs[i].d_done);
      exp_bad  = exp_bad + 16'(vecs[i].d_bad);
      wait_out(base + 2, 40, $sformatf("vec%0d_done", i));
      check($sformatf("vec%0d_consumed", i), xsim_pkg::sink_q.size(), 0);
      if (out_edge_q.size() >= base + 2) begin
        check($sformatf("vec%0d_hdr_lat", i), out_edge_q[base] - last_acc_edge, 2);
        check($sformatf("vec%0d_pay_lat", i), out_edge_q[base + 1] - last_acc_edge, 3);
      end
      check($sformatf("vec%0d_msgs_done", i), msgs_done, exp_done);
      check($sformatf("vec%0d_bad_msgs", i), {16'd0, bad_msgs}, {16'd0, exp_bad});
    end

    base = out_seen;
    for (int i = 0; i < 20; i++) begin
      xsim_pkg::sink_q.push_back(32'h0000_0002);
      xsim_pkg::sink_q.push_back(32'h1000_0000 + i);
      exp_q.push_back(32'h0000_0002);
      exp_q.push_back(32'h1000_0000 + i);
    end
    exp_done = exp_done + 32'd20;
    wait_out(base + 40, 400, "stream_done");
    check("stream_msgs_done", msgs_done, exp_done);
    check("stream_fifo_bound", 32'(max_count <= DEPTH), 32'd1);

    a0 = xsim_pkg::sink_accepts;
    xsim_pkg::sink_q.push_back(32'h0000_0002);
    k = 0;
    while (xsim_pkg::sink_accepts == a0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("partial_hdr_accepted", xsim_pkg::sink_accepts, a0 + 1);
    rst    = 1'b1;
    calls0 = xsim_pkg::sink_calls;
    src0   = xsim_pkg::src_calls;
    repeat (3) @(negedge clk);
    #1;
    check("rst_no_sink_calls", xsim_pkg::sink_calls, calls0);
    check("rst_no_src_calls", xsim_pkg::src_calls, src0);
    check("rst_msgs_done", msgs_done, 32'd0);
    check("rst_bad_msgs", {16'd0, bad_msgs}, 32'd0);
    rst = 1'b0;
    base = out_seen;
    xsim_pkg::sink_q.push_back(32'h0001_0003);
    xsim_pkg::sink_q.push_back(32'h0000_0001);
    xsim_pkg::sink_q.push_back(32'h0000_0002);
    exp_q.push_back(32'h0001_0002);
    exp_q.push_back(32'h0000_0003);
    wait_out(base + 2, 40, "post_rst_done");
    check("post_rst_msgs_done", msgs_done, 32'd1);
    check("sink_portal", xsim_pkg::last_sink_portal, 0);
    check("src_portal", xsim_pkg::last_src_portal, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
